// File: rtl/sig_dump_ctrl.sv
// End-of-test controller: watches the compliance handshake stores, halts the CPU, reports
// pass/fail/timeout and (with SIG_DUMP_EN defined) streams the signature region out of memory.
module sig_dump_ctrl #(
    parameter int unsigned   AW          = 32,
    parameter logic [AW-1:0] TOHOST_ADDR = AW'(32'h0000_1000),
    parameter int unsigned   TIMEOUT_CYC = 5000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_we,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_wdata,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [31:0]   mem_rd_data,
    output logic          halt,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [30:0]   fail_num,
    output logic          sig_valid,
    input  logic          sig_ready,
    output logic [31:0]   sig_data,
    output logic          sig_last,
    output logic          sig_err
);

    localparam logic [AW-1:0] BEGIN_ADDR = TOHOST_ADDR + AW'(4);
    localparam logic [AW-1:0] END_ADDR   = TOHOST_ADDR + AW'(8);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
`ifdef SIG_DUMP_EN
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   run_cnt;
    logic [AW-1:0] begin_q, end_q;
    logic          run_active, st_ok, tohost_end, timeout_hit, timeout_end, leaving;

    // RUN with halt already set is the single decision cycle between the run and the dump.
    assign run_active  = (state == S_RUN) && !halt;
    assign leaving     = (state == S_RUN) && halt;
    assign st_ok       = st_we && run_active;
    assign tohost_end  = st_ok && (st_addr == TOHOST_ADDR) && st_wdata[0];
    assign timeout_hit = (TIMEOUT_CYC != 0) && (run_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout_end = run_active && timeout_hit && !tohost_end;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of the order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            begin_q  <= '0;
            end_q    <= '0;
            halt     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            fail_num <= '0;
        end else begin
            if (run_active)
                run_cnt <= run_cnt + 32'd1;
            if (st_ok && (st_addr == BEGIN_ADDR))
                begin_q <= AW'(st_wdata);
            if (st_ok && (st_addr == END_ADDR))
                end_q <= AW'(st_wdata);
            if (tohost_end || timeout_end)
                halt <= 1'b1;
            if (tohost_end) begin
                pass     <= (st_wdata == 32'd1);
                fail_num <= (st_wdata == 32'd1) ? 31'd0 : st_wdata[31:1];
            end
            if (timeout_end)
                timeout <= 1'b1;
        end
    end

`ifdef SIG_DUMP_EN
    logic [AW-1:0] ptr, ptr_next4;
    logic [31:0]   sig_data_q;
    logic          sig_err_q, bounds_bad, last_c;

    assign bounds_bad = (begin_q >= end_q) || (begin_q[1:0] != 2'b00) || (end_q[1:0] != 2'b00);
    // end_q > begin_q and both aligned, so ptr+4 never wraps before reaching end_q.
    assign ptr_next4  = ptr + AW'(4);
    assign last_c     = (ptr_next4 >= end_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            sig_data_q <= '0;
            sig_err_q  <= 1'b0;
        end else begin
            if (leaving) begin
                ptr <= begin_q;
                if (bounds_bad)
                    sig_err_q <= 1'b1;
            end
            if (state == S_WAIT)
                sig_data_q <= mem_rd_data;
            if ((state == S_PRESENT) && sig_ready && !last_c)
                ptr <= ptr_next4;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{mem_rd_data, sig_ready, begin_q, end_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN: begin
                if (leaving) begin
`ifdef SIG_DUMP_EN
                    state_nxt = bounds_bad ? S_DONE : S_FETCH;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef SIG_DUMP_EN
            S_FETCH:   state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (sig_ready)
                    state_nxt = last_c ? S_DONE : S_FETCH;
            end
`endif
            S_DONE:    state_nxt = S_DONE;
            default:   state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        done        = (state == S_DONE);
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        sig_valid   = 1'b0;
        sig_last    = 1'b0;
`ifdef SIG_DUMP_EN
        sig_data    = sig_data_q;
        sig_err     = sig_err_q;
        if (state == S_FETCH) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = ptr;
        end
        if (state == S_PRESENT) begin
            sig_valid = 1'b1;
            sig_last  = last_c;
        end
`else
        sig_data    = '0;
        sig_err     = 1'b0;
`endif
    end

endmodule
